// File: rtl/dop_frame_check_if.sv
// Frame-side and payload-side signals of the DoP marker checker, bundled for
// the link between the I2S receiver and the DSD transmitter.
interface dop_frame_check_if #(
    parameter int DW = 16
);
    logic          valid_i;
    logic [DW+7:0] ldata_i;
    logic [DW+7:0] rdata_i;
    logic          valid_o;
    logic [DW-1:0] ldata_o;
    logic [DW-1:0] rdata_o;
    logic          dop_lock;
    logic          marker_err;

    modport master (
        output valid_i, ldata_i, rdata_i,
        input  valid_o, ldata_o, rdata_o, dop_lock, marker_err
    );

    modport slave (
        input  valid_i, ldata_i, rdata_i,
        output valid_o, ldata_o, rdata_o, dop_lock, marker_err
    );
endinterface

// File: rtl/dop_frame_check.sv
// DoP marker checker: acquires lock on alternating 0x05/0xFA markers, strips
// them, and forwards DSD payload, substituting idle silence on marker errors.
module dop_frame_check #(
    parameter int          DW         = 16,
    parameter int          LOCK_CNT   = 32,
    parameter int          UNLOCK_CNT = 4,
    parameter logic [7:0]  IDLE_BYTE  = 8'h69
) (
    input  logic              bclk,
    input  logic              rst,
    dop_frame_check_if.slave  bus
);
    localparam int LCW = $clog2(LOCK_CNT + 1);
    localparam int UCW = $clog2(UNLOCK_CNT + 1);
    localparam logic [LCW-1:0] LOCK_MAX   = LCW'(LOCK_CNT);
    localparam logic [UCW-1:0] UNLOCK_MAX = UCW'(UNLOCK_CNT);

    localparam logic [1:0] SEARCH  = 2'd0;
    localparam logic [1:0] LOCKING = 2'd1;
    localparam logic [1:0] LOCKED  = 2'd2;

    localparam logic [7:0]    MARK_A    = 8'h05;
    localparam logic [7:0]    MARK_B    = 8'hFA;
    localparam logic [DW-1:0] IDLE_WORD = {(DW/8){IDLE_BYTE}};

    function automatic logic [LCW-1:0] lock_inc(input logic [LCW-1:0] c);
        return (c == LOCK_MAX) ? c : c + LCW'(1);
    endfunction

    function automatic logic [UCW-1:0] err_inc(input logic [UCW-1:0] c);
        return (c == UNLOCK_MAX) ? c : c + UCW'(1);
    endfunction

    logic [1:0]     state;
    logic [LCW-1:0] lock_cnt;
    logic [UCW-1:0] err_cnt;
    logic [7:0]     exp_mark;
    logic           vld_p1;
    logic           err_p1;
    logic [DW-1:0]  ldata_p1;
    logic [DW-1:0]  rdata_p1;

    // stage 0: marker classification of the incoming frame
    logic [7:0]     lmark_p0;
    logic [7:0]     rmark_p0;
    logic           same_p0;
    logic           cand_p0;
    logic           good_p0;
    logic [LCW-1:0] lock_nxt_p0;
    logic [UCW-1:0] err_nxt_p0;

    assign lmark_p0    = bus.ldata_i[DW+7:DW];
    assign rmark_p0    = bus.rdata_i[DW+7:DW];
    assign same_p0     = (lmark_p0 == rmark_p0);
    assign cand_p0     = same_p0 && (lmark_p0 == MARK_A || lmark_p0 == MARK_B);
    assign good_p0     = same_p0 && (lmark_p0 == exp_mark);
    assign lock_nxt_p0 = lock_inc(lock_cnt);
    assign err_nxt_p0  = err_inc(err_cnt);

    // stage 1: registered state and outputs
    always_ff @(posedge bclk or posedge rst) begin
        if (rst) begin
            state    <= SEARCH;
            lock_cnt <= '0;
            err_cnt  <= '0;
            exp_mark <= MARK_A;
            vld_p1   <= 1'b0;
            err_p1   <= 1'b0;
            ldata_p1 <= '0;
            rdata_p1 <= '0;
        end else begin
            vld_p1 <= 1'b0;
            err_p1 <= 1'b0;
            if (bus.valid_i) begin
                case (state)
                    SEARCH: begin
                        if (cand_p0) begin
                            state    <= LOCKING;
                            lock_cnt <= LCW'(1);
                            exp_mark <= ~lmark_p0;
                        end
                    end
                    LOCKING: begin
                        if (good_p0) begin
                            lock_cnt <= lock_nxt_p0;
                            exp_mark <= ~exp_mark;
                            if (lock_nxt_p0 == LOCK_MAX) begin
                                state   <= LOCKED;
                                err_cnt <= '0;
                            end
                        end else if (cand_p0) begin
                            lock_cnt <= LCW'(1);
                            exp_mark <= ~lmark_p0;
                        end else begin
                            state <= SEARCH;
                        end
                    end
                    LOCKED: begin
                        vld_p1   <= 1'b1;
                        exp_mark <= ~exp_mark;
                        if (good_p0) begin
                            ldata_p1 <= bus.ldata_i[DW-1:0];
                            rdata_p1 <= bus.rdata_i[DW-1:0];
                            err_cnt  <= '0;
                        end else begin
                            ldata_p1 <= IDLE_WORD;
                            rdata_p1 <= IDLE_WORD;
                            err_p1   <= 1'b1;
                            err_cnt  <= err_nxt_p0;
                            // Persistent errors: last substituted frame still goes out.
                            if (err_nxt_p0 == UNLOCK_MAX) begin
                                state    <= SEARCH;
                                exp_mark <= MARK_A;
                            end
                        end
                    end
                    default: state <= SEARCH;
                endcase
            end
        end
    end

    assign bus.valid_o    = vld_p1;
    assign bus.marker_err = err_p1;
    assign bus.ldata_o    = ldata_p1;
    assign bus.rdata_o    = rdata_p1;
    assign bus.dop_lock   = (state == LOCKED);
endmodule

// File: tb/tb_dop_frame_check.sv
// Scenario bench for dop_frame_check: lock acquisition, error substitution,
// loss of lock, restarts and asynchronous reset, checked via a scoreboard.
module tb_dop_frame_check;
    typedef struct {
        logic        v;
        logic        er;
        logic        lk;
        logic [15:0] l;
        logic [15:0] r;
    } exp_t;

    logic bclk;
    logic rst;
    int   pass_cnt;
    int   total_cnt;
    exp_t sb[$];
    logic [15:0] hold_l;
    logic [15:0] hold_r;

    dop_frame_check_if #(.DW(16)) dif ();

    dop_frame_check #(
        .DW(16), .LOCK_CNT(32), .UNLOCK_CNT(4), .IDLE_BYTE(8'h69)
    ) dut (
        .bclk(bclk),
        .rst (rst),
        .bus (dif.slave)
    );

    initial bclk = 1'b0;
    always #5 bclk = ~bclk;

    // Called at a falling edge; the frame is sampled at the next rising edge
    // and its result is checked at the falling edge after that.
    task automatic send_frame(input logic [7:0] lm, input logic [15:0] lp,
                              input logic [7:0] rm, input logic [15:0] rp,
                              input logic ev, input logic eer, input logic elk,
                              input int gap, input string tag);
        exp_t e;
        e.v  = ev;
        e.er = eer;
        e.lk = elk;
        if (ev) begin
            hold_l = eer ? 16'h6969 : lp;
            hold_r = eer ? 16'h6969 : rp;
        end
        e.l = hold_l;
        e.r = hold_r;
        sb.push_back(e);
        dif.valid_i = 1'b1;
        dif.ldata_i = {lm, lp};
        dif.rdata_i = {rm, rp};
        @(negedge bclk);
        dif.valid_i = 1'b0;
        e = sb.pop_front();
        total_cnt++;
        if (dif.valid_o !== e.v) $display("FAIL %s valid_o got %b want %b", tag, dif.valid_o, e.v);
        else pass_cnt++;
        total_cnt++;
        if (dif.marker_err !== e.er) $display("FAIL %s marker_err got %b want %b", tag, dif.marker_err, e.er);
        else pass_cnt++;
        total_cnt++;
        if (dif.dop_lock !== e.lk) $display("FAIL %s dop_lock got %b want %b", tag, dif.dop_lock, e.lk);
        else pass_cnt++;
        total_cnt++;
        if (dif.ldata_o !== e.l) $display("FAIL %s ldata_o got %h want %h", tag, dif.ldata_o, e.l);
        else pass_cnt++;
        total_cnt++;
        if (dif.rdata_o !== e.r) $display("FAIL %s rdata_o got %h want %h", tag, dif.rdata_o, e.r);
        else pass_cnt++;
        for (int k = 1; k < gap; k++) begin
            @(negedge bclk);
            total_cnt++;
            if (dif.valid_o !== 1'b0 || dif.marker_err !== 1'b0)
                $display("FAIL %s idle pulses got %b%b want 00", tag, dif.valid_o, dif.marker_err);
            else pass_cnt++;
            total_cnt++;
            if (dif.dop_lock !== e.lk || dif.ldata_o !== hold_l || dif.rdata_o !== hold_r)
                $display("FAIL %s idle hold got %b %h %h want %b %h %h", tag,
                         dif.dop_lock, dif.ldata_o, dif.rdata_o, e.lk, hold_l, hold_r);
            else pass_cnt++;
        end
    endtask

    // n alternating frames starting at 'first'; lock expected on frame lock_at (0 = never).
    task automatic run_good(input int n, input logic [7:0] first, input int lock_at,
                            input int gap, input string tag);
        logic [7:0] m;
        logic       lk;
        for (int i = 1; i <= n; i++) begin
            m  = (i % 2 == 1) ? first : ~first;
            lk = (lock_at != 0) && (i >= lock_at);
            send_frame(m, 16'h1234, m, 16'hABCD, (lock_at != 0) && (i > lock_at),
                       1'b0, lk, gap, tag);
        end
    endtask

    task automatic unlock_pcm(input int gap, input string tag);
        for (int i = 1; i <= 4; i++)
            send_frame(8'h00, 16'h0BAD, 8'h00, 16'h0BAD, 1'b1, 1'b1, (i < 4), gap, tag);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        dif.valid_i = 1'b0;
        dif.ldata_i = '0;
        dif.rdata_i = '0;
        hold_l = '0;
        hold_r = '0;
        repeat (3) @(negedge bclk);
        total_cnt++;
        if ({dif.valid_o, dif.marker_err, dif.dop_lock} !== 3'b000)
            $display("FAIL reset flags got %b want 000", {dif.valid_o, dif.marker_err, dif.dop_lock});
        else pass_cnt++;
        total_cnt++;
        if (dif.ldata_o !== 16'h0 || dif.rdata_o !== 16'h0)
            $display("FAIL reset data got %h %h want 0000 0000", dif.ldata_o, dif.rdata_o);
        else pass_cnt++;
        rst = 1'b0;
        @(negedge bclk);
    endtask

    task automatic test_lock_acquire();
        run_good(40, 8'h05, 32, 8, "lock_acquire");
    endtask

    task automatic test_single_error();
        send_frame(8'hFA, 16'h5555, 8'hFA, 16'h0F0F, 1'b1, 1'b1, 1'b1, 8, "single_err");
        send_frame(8'hFA, 16'h5555, 8'hFA, 16'h0F0F, 1'b1, 1'b0, 1'b1, 8, "err_recover");
    endtask

    task automatic test_pcm_unlock();
        unlock_pcm(4, "pcm_unlock");
        for (int i = 0; i < 3; i++)
            send_frame(8'h00, 16'h0BAD, 8'h00, 16'h0BAD, 1'b0, 1'b0, 1'b0, 4, "pcm_search");
    endtask

    task automatic test_locking_abort();
        run_good(20, 8'h05, 0, 2, "locking_pre");
        send_frame(8'h05, 16'h1111, 8'hFA, 16'h2222, 1'b0, 1'b0, 1'b0, 2, "lr_split");
        run_good(32, 8'h05, 32, 2, "relock_full");
        unlock_pcm(1, "pcm_b2b");
    endtask

    task automatic test_restart();
        run_good(9, 8'h05, 0, 1, "restart_pre");
        send_frame(8'h05, 16'h1234, 8'h05, 16'hABCD, 1'b0, 1'b0, 1'b0, 1, "repeat_05");
        run_good(31, 8'hFA, 31, 1, "restart_31");
    endtask

    task automatic test_back_to_back();
        send_frame(8'h05, 16'hC001, 8'h05, 16'hD001, 1'b1, 1'b0, 1'b1, 1, "b2b_0");
        send_frame(8'hFA, 16'hC002, 8'hFA, 16'hD002, 1'b1, 1'b0, 1'b1, 1, "b2b_1");
        send_frame(8'h05, 16'hC003, 8'h05, 16'hD003, 1'b1, 1'b0, 1'b1, 1, "b2b_2");
    endtask

    task automatic test_reset_midstream();
        dif.valid_i = 1'b1;
        dif.ldata_i = {8'hFA, 16'h2468};
        dif.rdata_i = {8'hFA, 16'h1357};
        @(posedge bclk);
        #1;
        total_cnt++;
        if (dif.valid_o !== 1'b1 || dif.ldata_o !== 16'h2468)
            $display("FAIL pre_reset got %b %h want 1 2468", dif.valid_o, dif.ldata_o);
        else pass_cnt++;
        rst = 1'b1;
        dif.valid_i = 1'b0;
        #1;
        total_cnt++;
        if ({dif.valid_o, dif.marker_err, dif.dop_lock} !== 3'b000)
            $display("FAIL async_reset flags got %b want 000", {dif.valid_o, dif.marker_err, dif.dop_lock});
        else pass_cnt++;
        total_cnt++;
        if (dif.ldata_o !== 16'h0 || dif.rdata_o !== 16'h0)
            $display("FAIL async_reset data got %h %h want 0000 0000", dif.ldata_o, dif.rdata_o);
        else pass_cnt++;
        @(negedge bclk);
        rst = 1'b0;
        hold_l = '0;
        hold_r = '0;
        run_good(32, 8'hFA, 32, 2, "post_reset");
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        test_reset();
        test_lock_acquire();
        test_single_error();
        test_pcm_unlock();
        test_locking_abort();
        test_restart();
        test_back_to_back();
        test_reset_midstream();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
